rf_wr_arbiter: RTL and testbench
================================

# rf_wr_arbiter

Round-robin arbiter that shares the register file's single write port among `NREQ` writeback requesters (ALU, load unit, debug/switch input, …). Each requester presents an address/data pair with a valid/ready handshake. The block grants at most one per cycle and drives the register file's `RFWr`/`A3`/`WD` write inputs from a registered output stage. Writes to register 0 are accepted and dropped, and a freeze input stalls all writeback for board-level single-stepping.

## Interface
- `NREQ`, 3: number of requesters (2..8).
- `AW`, 5: register address width.
- `DW`, 32: data width.
- `CW`, 16: width of write/drop statistics counters.

- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `freeze`  in  1  1 = stall: no grants, no writes.
- `req_valid`  in  NREQ  per-requester valid.
- `req_addr`  in  NREQ*AW  packed addresses, requester i at bits [i*AW +: AW].
- `req_data`  in  NREQ*DW  packed data, requester i at bits [i*DW +: DW].
- `req_ready`  out  NREQ  one-hot-or-zero grant, combinational.
- `RFWr`  out  1  registered write enable to register file.
- `A3`  out  AW  registered write address.
- `WD`  out  DW  registered write data.
- `wr_count`  out  CW  saturating count of writes issued (RFWr pulses).
- `drop_count`  out  CW  saturating count of accepted writes to address 0.

## Operation
- Transfer on requester i = `req_valid[i] & req_ready[i]` at a rising edge.
- `req_ready` is combinational from `req_valid`, `freeze` and the priority pointer `ptr`.
  - When `freeze`=1, `req_ready` = 0.
  - Otherwise, `req_ready` has a single 1 at the first valid index searched from `ptr` upward, wrapping modulo NREQ.
  - With no valid request, `req_ready` = 0.
- `ptr` (width clog2(NREQ)) updates only on a transfer, to granted index + 1, wrapping to 0 after NREQ-1. It holds otherwise.
- Output stage, loaded every edge:
  - Transfer with addr ≠ 0: `RFWr`=1, `A3`=addr, `WD`=data; `wr_count` increments.
  - Transfer with addr = 0: `RFWr`=0, `A3`/`WD` hold; `drop_count` increments.
  - No transfer (including freeze): `RFWr`=0, `A3`/`WD` hold.
- Counters saturate at 2^CW-1 and never wrap.
- A requester must hold `req_valid`, `req_addr` and `req_data` stable until it sees `req_ready`. The arbiter does not latch unaccepted requests.
- No ordering is guaranteed between different requesters. Two requesters targeting the same address are written in grant order.

## Timing
- Reset (`rst`=0, asynchronous): `RFWr`=0, `A3`=0, `WD`=0, `ptr`=0, `wr_count`=0, `drop_count`=0.
- `req_ready` is forced 0 while `rst`=0.
- Release of `rst` is synchronised internally by the parent's reset synchroniser. The first grant is possible in the first cycle with `rst`=1.
- Latency: transfer at edge N → `RFWr`=1 during cycle N..N+1 → register file captures at edge N+1.
- Throughput: one write per cycle. Back-to-back grants give continuous `RFWr`=1 with a new `A3`/`WD` each cycle.
- Freeze asserted in cycle k: no transfer at edge k. A write already registered at edge k-1 still completes, because `RFWr` stays high through cycle k. `RFWr` is 0 from edge k onward.
- Freeze deasserted: grants resume the same cycle with the `ptr` value held from before the freeze.
- Reset mid-operation: the pending registered write is discarded, since `RFWr` goes to 0 immediately. Requesters must re-present.
- Fairness: a continuously valid requester is granted within NREQ cycles while `freeze`=0.

## Structure
- Shared package `rf_pkg`: `RF_AW`=5, `RF_DW`=32, `RF_NREGS`=32, and the requester index constants `REQ_ALU`=0, `REQ_LOAD`=1, `REQ_DBG`=2.
- Sub-module `rr_arbiter` (parameter N): inputs `req[N]`, `ptr`, `en`; outputs `gnt[N]` one-hot and `gnt_idx`. It is purely combinational.
- `rf_wr_arbiter` holds `ptr`, the output stage registers, the counters and the address-0 filter.

## Test plan
- Single request: requester 1 valid, addr 7, data 0xDEADBEEF.
  - Expect `req_ready`=3'b010 that cycle.
  - Next cycle: `RFWr`=1, `A3`=7, `WD`=0xDEADBEEF.
  - The cycle after: `RFWr`=0, `wr_count`=1.
- All three valid continuously from `ptr`=0, addresses 1, 2, 3.
  - Grants are 0, 1, 2, 0, 1, 2…
  - `A3` sequence is 1, 2, 3, 1, …, with `RFWr` continuously 1.
- Address 0: requester 0 valid, addr 0, data 0x55.
  - Expect `req_ready`[0]=1.
  - `RFWr` stays 0, `drop_count`=1, `wr_count` unchanged, `A3`/`WD` hold.
- Freeze: requester 2 valid throughout; assert `freeze` for 4 cycles right after one grant.
  - The in-flight write completes.
  - `req_ready`=0 and `RFWr`=0 for the 4 cycles.
  - The grant resumes in the first unfrozen cycle.
- Async reset while `RFWr`=1 (drop `rst` between edges):
  - `RFWr`/`A3`/`WD`/counters go to 0 before the next edge.
  - After release, requester 0 is granted first (`ptr`=0).
- Saturation with `CW`=4: issue 20 writes → `wr_count`=15 and holds.

Source files
------------

// File: rtl/rf_pkg.sv
// Register-file constants shared by the writeback path.
// Widths, register count and requester slot indices.
package rf_pkg;

  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;
  localparam int RF_NREGS = 32;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_DBG  = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req at or above ptr, wrapping.
// Ports: req/ptr/en in; one-hot gnt and its index gnt_idx out.
module rr_arbiter
  import rf_pkg::*;
#(
  parameter  int N  = 3,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  logic hit;
  int   j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    hit     = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (en && !hit && req[j]) begin
        gnt[j]  = 1'b1;
        gnt_idx = PW'(j);
        hit     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Shares the register-file write port among NREQ writeback requesters.
// Ports: freeze, req_valid/addr/data in; req_ready, RFWr/A3/WD, counters out.
module rf_wr_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW,
  parameter int CW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              RFWr,
  output logic [AW-1:0]     A3,
  output logic [DW-1:0]     WD,
  output logic [CW-1:0]     wr_count,
  output logic [CW-1:0]     drop_count
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_nxt;
  logic [PW-1:0]   gnt_idx;
  logic [NREQ-1:0] gnt;
  logic            xfer;
  logic            zero;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  // rst gates the grant so nothing is accepted while held in reset
  rr_arbiter #(
    .N (NREQ)
  ) u_rr (
    .req     (req_valid),
    .ptr     (ptr),
    .en      (~freeze & rst),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign sel_addr  = req_addr[int'(gnt_idx)*AW +: AW];
  assign sel_data  = req_data[int'(gnt_idx)*DW +: DW];
  assign zero      = (sel_addr == '0);
  assign ptr_nxt   = (gnt_idx == PW'(NREQ - 1)) ? '0
                   : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr        <= '0;
      RFWr       <= 1'b0;
      A3         <= '0;
      WD         <= '0;
      wr_count   <= '0;
      drop_count <= '0;
    end else begin
      RFWr <= xfer & ~zero;
      if (xfer) ptr <= ptr_nxt;
      if (xfer && !zero) begin
        A3 <= sel_addr;
        WD <= sel_data;
        if (wr_count != '1) wr_count <= wr_count + 1'b1;
      end
      if (xfer && zero) begin
        if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: directed scenarios then random traffic.
// Reference model scans requesters from a pointer and tracks outputs.
module tb_rf_wr_arbiter;

  localparam int N   = 3;
  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int CW  = 4;
  localparam int MAX = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          freeze;
  logic [N-1:0]  req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          RFWr;
  logic [AW-1:0] A3;
  logic [DW-1:0] WD;
  logic [CW-1:0] wr_count;
  logic [CW-1:0] drop_count;

  rf_wr_arbiter #(
    .NREQ (N),
    .AW   (AW),
    .DW   (DW),
    .CW   (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .freeze     (freeze),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .RFWr       (RFWr),
    .A3         (A3),
    .WD         (WD),
    .wr_count   (wr_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int          m_ptr;
  logic        m_we;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d;
  int          m_wr;
  int          m_drop;
  int          last_g;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (!freeze && rst && req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr  = 0;
    m_we   = 1'b0;
    m_a    = '0;
    m_d    = '0;
    m_wr   = 0;
    m_drop = 0;
  endtask

  task automatic set_req(input int i, input logic v,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = a;
    req_data[i*DW +: DW]  = d;
  endtask

  // Called at a falling edge with inputs already applied.
  task automatic cyc();
    int g;
    logic [N-1:0] er;
    logic [AW-1:0] a;
    #1;
    g  = pick();
    er = (g < 0) ? '0 : (N'(1) << g);
    chk("ready", req_ready, er);
    chk("rfwr_pre", RFWr, m_we);
    @(posedge clk);
    if (g >= 0) begin
      a = req_addr[g*AW +: AW];
      if (a != '0) begin
        m_we = 1'b1;
        m_a  = a;
        m_d  = req_data[g*DW +: DW];
        if (m_wr < MAX) m_wr++;
      end else begin
        m_we = 1'b0;
        if (m_drop < MAX) m_drop++;
      end
      m_ptr = (g + 1) % N;
    end else begin
      m_we = 1'b0;
    end
    last_g = g;
    #1;
    chk("rfwr", RFWr, m_we);
    chk("a3", A3, m_a);
    chk("wd", WD, m_d);
    chk("wr_count", wr_count, m_wr);
    chk("drop_count", drop_count, m_drop);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_ready", req_ready, 0);
    chk("rst_rfwr", RFWr, 0);
    chk("rst_a3", A3, 0);
    chk("rst_wd", WD, 0);
    chk("rst_wr", wr_count, 0);
    chk("rst_drop", drop_count, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    freeze    = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    last_g    = -1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_reset();

    // Single request on requester 1
    set_req(1, 1'b1, 5'd7, 32'hDEADBEEF);
    #1;
    chk("single_ready", req_ready, 3'b010);
    #1;
    cyc();
    chk("single_rfwr", RFWr, 1);
    chk("single_a3", A3, 7);
    chk("single_wd", WD, 32'hDEADBEEF);
    set_req(1, 1'b0, '0, '0);
    cyc();
    chk("single_done", RFWr, 0);
    chk("single_cnt", wr_count, 1);

    // All three continuously valid from ptr 0
    do_reset();
    set_req(0, 1'b1, 5'd1, 32'h11);
    set_req(1, 1'b1, 5'd2, 32'h22);
    set_req(2, 1'b1, 5'd3, 32'h33);
    for (int c = 0; c < 6; c++) begin
      logic [N-1:0] eg;
      eg = N'(1) << (c % 3);
      #1;
      chk("rr_grant", req_ready, eg);
      cyc();
      chk("rr_a3", A3, (c % 3) + 1);
      chk("rr_cont", RFWr, 1);
    end
    req_valid = '0;
    cyc();

    // Address 0 is accepted and dropped
    set_req(0, 1'b1, 5'd0, 32'h55);
    #1;
    chk("a0_ready", req_ready[0], 1);
    #1;
    cyc();
    chk("a0_rfwr", RFWr, 0);
    chk("a0_a3_hold", A3, 3);
    chk("a0_drop", drop_count, 1);
    req_valid = '0;

    // Freeze for 4 cycles right after a grant
    set_req(2, 1'b1, 5'd12, 32'hCAFE0012);
    cyc();
    chk("frz_pre", RFWr, 1);
    freeze = 1'b1;
    #1;
    chk("frz_inflight", RFWr, 1);
    #1;
    for (int c = 0; c < 4; c++) begin
      cyc();
      chk("frz_rfwr", RFWr, 0);
    end
    freeze = 1'b0;
    #1;
    chk("frz_resume", req_ready, 3'b100);
    #1;
    cyc();
    chk("frz_after", RFWr, 1);
    req_valid = '0;

    // Async reset while a write is registered
    set_req(1, 1'b1, 5'd9, 32'h99);
    cyc();
    chk("ar_pre", RFWr, 1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("ar_rfwr", RFWr, 0);
    chk("ar_a3", A3, 0);
    chk("ar_wd", WD, 0);
    chk("ar_wr", wr_count, 0);
    chk("ar_ready", req_ready, 0);
    @(negedge clk);
    set_req(0, 1'b1, 5'd4, 32'h44);
    set_req(1, 1'b1, 5'd5, 32'h55);
    set_req(2, 1'b1, 5'd6, 32'h66);
    cyc();
    rst = 1'b1;
    #1;
    chk("ar_first", req_ready, 3'b001);
    #1;
    cyc();
    req_valid = '0;

    // Saturation of the 4-bit write counter
    do_reset();
    for (int c = 0; c < 20; c++) begin
      set_req(0, 1'b1, 5'd5, $urandom);
      cyc();
    end
    chk("sat_wr", wr_count, 15);
    req_valid = '0;

    // Random traffic with held requests
    do_reset();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_g == i) begin
          logic [AW-1:0] a;
          a = ($urandom % 4 == 0) ? '0 : AW'($urandom);
          set_req(i, ($urandom % 4) != 0, a, $urandom);
        end
      end
      freeze = ($urandom % 8) == 0;
      cyc();
    end
    freeze    = 1'b0;
    req_valid = '0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
